// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the core stages and pipe_ctrl: stall requests,
// EX branch resolution in; stall vector, flush/redirect and fetch-discard out.
interface pipe_ctrl_if #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned ADDR_W  = 32
);
  logic               rdy;
  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_mem;
  logic               branch_flush_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic               redirect_we_o;
  logic [ADDR_W-1:0]  redirect_pc_o;
  logic               if_discard_o;

  modport master (
    output rdy, stallreq_if, stallreq_id, stallreq_mem, branch_flush_i, branch_target_i,
    input  stall_o, flush_o, redirect_we_o, redirect_pc_o, if_discard_o
  );

  modport slave (
    input  rdy, stallreq_if, stallreq_id, stallreq_mem, branch_flush_i, branch_target_i,
    output stall_o, flush_o, redirect_we_o, redirect_pc_o, if_discard_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage core: merges stage stall requests and sequences EX branch flushes.
// Define PIPE_PERF_EN to add saturating perf counters for stall winners and issued flushes.
module pipe_ctrl #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned ADDR_W  = 32
`ifdef PIPE_PERF_EN
  ,
  parameter int unsigned PERF_W  = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_mem_cyc_o,
  output logic [PERF_W-1:0] perf_id_cyc_o,
  output logic [PERF_W-1:0] perf_if_cyc_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD_FLUSH = 2'd1,
    DRAIN_IF   = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] ST_MEM = {1'b0, {(STALL_W-1){1'b1}}};
  localparam logic [STALL_W-1:0] ST_ID  = STALL_W'(3'b111);
  localparam logic [STALL_W-1:0] ST_IF  = STALL_W'(2'b11);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               flush_fire;
  logic               id_eff;
  logic [STALL_W-1:0] stall_vec;
  logic [ADDR_W-1:0]  pc_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // A branch that cannot flush immediately (MEM busy or core frozen) is parked in
  // HOLD_FLUSH with its target; the still-asserted branch_flush_i is then ignored,
  // so the flush issues exactly once.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    flush_fire = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.branch_flush_i) begin
          if (bus.rdy && !bus.stallreq_mem) begin
            flush_fire = 1'b1;
            if (bus.stallreq_if) state_d = DRAIN_IF;
          end else begin
            target_d = bus.branch_target_i;
            state_d  = HOLD_FLUSH;
          end
        end
      end
      HOLD_FLUSH: begin
        if (bus.rdy && !bus.stallreq_mem) begin
          flush_fire = 1'b1;
          state_d    = bus.stallreq_if ? DRAIN_IF : RUN;
        end
      end
      DRAIN_IF: begin
        if (bus.rdy && !bus.stallreq_if) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_vec = '0;
    if (flush_fire) pc_vec = (state_q == HOLD_FLUSH) ? target_q : bus.branch_target_i;
  end

  // The load-use requester is being killed by the flush, so it must not hold the front end.
  assign id_eff = bus.stallreq_id && !flush_fire;

  always_comb begin
    stall_vec = '0;
    if (!bus.rdy)             stall_vec = '1;
    else if (bus.stallreq_mem) stall_vec = ST_MEM;
    else if (id_eff)           stall_vec = ST_ID;
    else if (bus.stallreq_if)  stall_vec = ST_IF;
  end

  assign bus.stall_o       = rst ? stall_vec : '0;
  assign bus.flush_o       = rst && flush_fire;
  assign bus.redirect_we_o = rst && flush_fire;
  assign bus.redirect_pc_o = rst ? pc_vec : '0;
  assign bus.if_discard_o  = rst && (state_q == DRAIN_IF);

  a_no_branch_in_drain: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == DRAIN_IF && bus.branch_flush_i));

`ifdef PIPE_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mem_cyc_o <= '0;
      perf_id_cyc_o  <= '0;
      perf_if_cyc_o  <= '0;
      perf_flush_o   <= '0;
    end else begin
      if (bus.rdy && bus.stallreq_mem)
        perf_mem_cyc_o <= sat_inc(perf_mem_cyc_o);
      if (bus.rdy && !bus.stallreq_mem && id_eff)
        perf_id_cyc_o <= sat_inc(perf_id_cyc_o);
      if (bus.rdy && !bus.stallreq_mem && !id_eff && bus.stallreq_if)
        perf_if_cyc_o <= sat_inc(perf_if_cyc_o);
      if (flush_fire)
        perf_flush_o <= sat_inc(perf_flush_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed cycle-by-cycle vectors for pipe_ctrl plus a hand-written async-reset-mid-drain sequence.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  pipe_ctrl_if #(.STALL_W(6), .ADDR_W(32)) bus ();

`ifdef PIPE_PERF_EN
  logic [31:0] p_mem, p_id, p_if, p_fl;
  pipe_ctrl #(.STALL_W(6), .ADDR_W(32), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_mem_cyc_o(p_mem), .perf_id_cyc_o(p_id), .perf_if_cyc_o(p_if), .perf_flush_o(p_fl)
  );
`else
  pipe_ctrl #(.STALL_W(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  in;    // {rdy, mem, id, if, branch}
    logic [31:0] tgt;
    logic [5:0]  stall;
    logic        flush; // redirect_we must equal flush
    logic [31:0] pc;
    logic        disc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] tgt, input logic [5:0] st,
                              input logic fl, input logic [31:0] pc, input logic disc);
    vec_t v;
    v.in = in; v.tgt = tgt; v.stall = st; v.flush = fl; v.pc = pc; v.disc = disc;
    return v;
  endfunction

  task automatic drive(input logic [4:0] in, input logic [31:0] tgt);
    bus.rdy             = in[4];
    bus.stallreq_mem    = in[3];
    bus.stallreq_id     = in[2];
    bus.stallreq_if     = in[1];
    bus.branch_flush_i  = in[0];
    bus.branch_target_i = tgt;
  endtask

  task automatic check(input string name, input logic [5:0] st, input logic fl,
                       input logic [31:0] pc, input logic disc);
    n_run++;
    if (bus.stall_o !== st || bus.flush_o !== fl || bus.redirect_we_o !== fl ||
        bus.redirect_pc_o !== pc || bus.if_discard_o !== disc) begin
      n_fail++;
      $display("FAIL %s: got stall=%b flush=%b we=%b pc=%h disc=%b, want stall=%b flush=%b we=%b pc=%h disc=%b",
               name, bus.stall_o, bus.flush_o, bus.redirect_we_o, bus.redirect_pc_o, bus.if_discard_o,
               st, fl, fl, pc, disc);
    end
  endtask

  initial begin
    // reset idle / plain stall priority
    vecs[0]  = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);
    vecs[1]  = mk(5'b10100, 32'h0,   6'b000111, 0, 32'h0,   0);
    vecs[2]  = mk(5'b10100, 32'h0,   6'b000111, 0, 32'h0,   0);
    vecs[3]  = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);
    vecs[4]  = mk(5'b11100, 32'h0,   6'b011111, 0, 32'h0,   0);
    vecs[5]  = mk(5'b10010, 32'h0,   6'b000011, 0, 32'h0,   0);
    vecs[6]  = mk(5'b01110, 32'h0,   6'b111111, 0, 32'h0,   0);
    // branch under MEM stall: held three cycles, flushes with latched target as mem drops
    vecs[7]  = mk(5'b11001, 32'h100, 6'b011111, 0, 32'h0,   0);
    vecs[8]  = mk(5'b11001, 32'hDEAD,6'b011111, 0, 32'h0,   0);
    vecs[9]  = mk(5'b11001, 32'hDEAD,6'b011111, 0, 32'h0,   0);
    vecs[10] = mk(5'b10101, 32'hDEAD,6'b000000, 1, 32'h100, 0);
    vecs[11] = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);
    // branch with fetch in flight: one flush, discard through the drop cycle
    vecs[12] = mk(5'b10111, 32'h200, 6'b000011, 1, 32'h200, 0);
    vecs[13] = mk(5'b10010, 32'h0,   6'b000011, 0, 32'h0,   1);
    vecs[14] = mk(5'b10010, 32'h0,   6'b000011, 0, 32'h0,   1);
    vecs[15] = mk(5'b10010, 32'h0,   6'b000011, 0, 32'h0,   1);
    vecs[16] = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   1);
    vecs[17] = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);
    // core frozen during HOLD_FLUSH
    vecs[18] = mk(5'b11001, 32'h300, 6'b011111, 0, 32'h0,   0);
    vecs[19] = mk(5'b00001, 32'h0,   6'b111111, 0, 32'h0,   0);
    vecs[20] = mk(5'b01001, 32'h0,   6'b111111, 0, 32'h0,   0);
    vecs[21] = mk(5'b10001, 32'h0,   6'b000000, 1, 32'h300, 0);
    vecs[22] = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);
    // branch arriving while core frozen
    vecs[23] = mk(5'b00001, 32'h400, 6'b111111, 0, 32'h0,   0);
    vecs[24] = mk(5'b10001, 32'h0,   6'b000000, 1, 32'h400, 0);
    vecs[25] = mk(5'b10000, 32'h0,   6'b000000, 0, 32'h0,   0);

    drive(5'b10000, 32'h0);
    #2;
    check("in_reset", 6'b000000, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].in, vecs[i].tgt);
      #2;
      check($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].pc, vecs[i].disc);
    end

    // async reset while draining a fetch
    @(negedge clk);
    drive(5'b10011, 32'h500);
    #2;
    check("drain_entry", 6'b000011, 1, 32'h500, 0);
    @(negedge clk);
    drive(5'b10010, 32'h0);
    #2;
    check("drain_active", 6'b000011, 0, 32'h0, 1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async", 6'b000000, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("post_rst_run", 6'b000011, 0, 32'h0, 0);
`ifdef PIPE_PERF_EN
    n_run++;
    if (p_mem !== 0 || p_id !== 0 || p_if !== 0 || p_fl !== 0) begin
      n_fail++;
      $display("FAIL perf_clear: got %0d %0d %0d %0d, want 0 0 0 0", p_mem, p_id, p_if, p_fl);
    end
`endif
    @(negedge clk);
    drive(5'b10000, 32'h0);
    #2;
    check("post_rst_idle", 6'b000000, 0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
